// File: rtl/bitvec_writer_if.sv
// Serial-bit load handshake and assembled-vector bundle for bitvec_writer.
// master drives the load controls; slave is the writer block.
interface bitvec_writer_if #(
    parameter int WIDTH = 32,
    parameter int ROW   = 8
);
    localparam int RW = (WIDTH / ROW > 1) ? $clog2(WIDTH / ROW) : 1;
    localparam int CW = $clog2(ROW);

    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [RW-1:0]    row_idx;
    logic [CW-1:0]    col_idx;
    logic [0:WIDTH-1] vec_out;

    modport master (
        output start, abort, in_valid, in_bit,
        input  in_ready, busy, done, row_idx, col_idx, vec_out
    );

    modport slave (
        input  start, abort, in_valid, in_bit,
        output in_ready, busy, done, row_idx, col_idx, vec_out
    );
endinterface

// File: rtl/bitvec_writer.sv
// Assembles a WIDTH-bit vector from serial bits, row by row, into a shadow
// register and commits it to vec_out only when the final bit lands.
module bitvec_writer #(
    parameter int WIDTH = 32,
    parameter int ROW   = 8
) (
    input logic           clk,
    input logic           rst_n,
    bitvec_writer_if.slave bus
);
    localparam int ROWS = WIDTH / ROW;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(ROW);
    localparam int IW   = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic [0:WIDTH-1] shadow;
    logic [0:WIDTH-1] shadow_nxt;
    logic [0:WIDTH-1] vec_q;
    logic [IW-1:0]    idx;
    logic             beat;
    logic             col_last;
    logic             last;

    assign idx      = IW'(row_q) * IW'(ROW) + IW'(col_q);
    assign col_last = (col_q == CW'(ROW - 1));
    assign last     = col_last && (row_q == RW'(ROWS - 1));
    // abort outranks a same-cycle beat, so it never counts as accepted
    assign beat     = (state == LOAD) && bus.in_valid && !bus.abort;

    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IW'(i)) shadow_nxt[i] = bus.in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD: begin
                if (bus.abort)        state_nxt = IDLE;
                else if (beat && last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == LOAD);
        bus.busy     = (state == LOAD);
        bus.done     = (state == DONE);
        bus.row_idx  = row_q;
        bus.col_idx  = col_q;
        bus.vec_out  = vec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            shadow <= '0;
            vec_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        row_q  <= '0;
                        col_q  <= '0;
                        shadow <= '0;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        row_q <= '0;
                        col_q <= '0;
                    end else if (beat) begin
                        shadow <= shadow_nxt;
                        if (last) begin
                            vec_q <= shadow_nxt;
                            row_q <= '0;
                            col_q <= '0;
                        end else if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
